lsu_mem_access: RTL and testbench

- Load/store access unit sitting directly upstream of the 1-write/2-read unified RAM's data port.
- Accepts one load or store per valid/ready handshake from the execute stage, checks alignment, and drives the RAM data-port signals for exactly one cycle.
- For stores it forms the 64-bit byte-lane write mask and shifted write data.
- For loads it captures the 64-bit RAM word, extracts the addressed lane and sign/zero-extends it, then returns a response to writeback via valid/ready.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_mem_access.sv | 130 +++++++++++++
 tb/tb_lsu_mem_access.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size/state encodings and RAM window defaults for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [63:0] DEF_RAM_BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DEF_RAM_SIZE = 64'h0000_0000_0800_0000;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - alignment check, store lane placement and load lane extraction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [2:0]  chk_offset,
  output logic        misalign,
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rd_data,
  output logic [63:0] wmask,
  output logic [63:0] wr_data,
  output logic [63:0] rdata_ext
);

  logic [5:0]  shamt;
  logic [7:0]  byte_mask;
  logic [63:0] lane;

  assign shamt   = {offset, 3'b000};
  assign wr_data = wdata << shamt;
  assign lane    = rd_data >> shamt;

  // Checked against the incoming request, not the latched one.
  always_comb begin
    misalign = 1'b0;
    case (chk_size)
      SZ_H:    misalign = chk_offset[0];
      SZ_W:    misalign = |chk_offset[1:0];
      SZ_D:    misalign = |chk_offset;
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    byte_mask = 8'h00;
    case (size)
      SZ_B:    byte_mask = 8'h01;
      SZ_H:    byte_mask = 8'h03;
      SZ_W:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
    byte_mask = byte_mask << offset;
    wmask = '0;
    for (int i = 0; i < 8; i++) begin
      wmask[i*8 +: 8] = {8{byte_mask[i]}};
    end
  end

  always_comb begin
    rdata_ext = '0;
    case (size)
      SZ_B:    rdata_ext = is_unsigned ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      SZ_H:    rdata_ext = is_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      SZ_W:    rdata_ext = is_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - load/store unit driving the unified RAM data port
// Optional address range fault enabled by defining LSU_RANGE_CHECK_EN.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter logic [63:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [63:0] RAM_SIZE = DEF_RAM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_fault,
  output logic        ram_rd_en,
  output logic        ram_wr_en,
  output logic [63:0] ram_wmask,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wr_data,
  input  logic [63:0] ram_rd_data
);

  state_e      state;
  logic        r_wen;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  logic        req_fire;
  logic        misalign_now;
  logic        fault_now;
  logic        in_access;
  logic [63:0] wmask_w;
  logic [63:0] wr_data_w;
  logic [63:0] rdata_w;

  assign req_ready = (state == IDLE) && !rst;
  assign req_fire  = req_valid && req_ready;
  assign in_access = (state == ACCESS);

`ifdef LSU_RANGE_CHECK_EN
  logic [64:0] end_addr;
  assign end_addr  = {1'b0, req_addr} + (65'd1 << req_size);
  assign fault_now = (req_addr < RAM_BASE) ||
                     (end_addr > ({1'b0, RAM_BASE} + {1'b0, RAM_SIZE}));
`else
  logic unused_range;
  assign unused_range = ^{RAM_BASE, RAM_SIZE};
  assign fault_now    = 1'b0;
`endif

  lsu_align u_align (
    .chk_size    (req_size),
    .chk_offset  (req_addr[2:0]),
    .misalign    (misalign_now),
    .size        (r_size),
    .offset      (r_addr[2:0]),
    .is_unsigned (r_unsigned),
    .wdata       (r_wdata),
    .rd_data     (ram_rd_data),
    .wmask       (wmask_w),
    .wr_data     (wr_data_w),
    .rdata_ext   (rdata_w)
  );

  // Write enable also looks at rst so a reset landing on ACCESS blocks the write.
  assign ram_rd_en   = in_access && !r_wen;
  assign ram_wr_en   = in_access && r_wen && !rst;
  assign ram_addr    = in_access ? {r_addr[63:3], 3'b000} : '0;
  assign ram_wmask   = in_access ? wmask_w : '0;
  assign ram_wr_data = in_access ? wr_data_w : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      resp_fault    <= 1'b0;
      r_wen         <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            r_wen         <= req_wen;
            r_unsigned    <= req_unsigned;
            r_size        <= req_size;
            r_addr        <= req_addr;
            r_wdata       <= req_wdata;
            resp_rdata    <= '0;
            resp_misalign <= misalign_now;
            resp_fault    <= fault_now;
            if (misalign_now || fault_now) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= r_wen ? '0 : rdata_w;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - self-checking bench for lsu_mem_access with a byte-level reference model
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_fault;
  logic        ram_rd_en;
  logic        ram_wr_en;
  logic [63:0] ram_wmask;
  logic [63:0] ram_addr;
  logic [63:0] ram_wr_data;
  logic [63:0] ram_rd_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .resp_fault    (resp_fault),
    .ram_rd_en     (ram_rd_en),
    .ram_wr_en     (ram_wr_en),
    .ram_wmask     (ram_wmask),
    .ram_addr      (ram_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_data   (ram_rd_data)
  );

  // 512-byte RAM window, aliased over the whole address space.
  logic [63:0] mem [0:63];
  logic        init_req = 1'b1;
  logic [7:0]  ref_mem [0:511];

  function automatic logic [63:0] init_word(input int i);
    if (i == 0) return 64'h1122_3344_F566_7788;
    if (i == 2) return 64'h0123_4567_89AB_CDEF;
    return 64'hA5C3_0F1E_2D3C_4B5A ^ (64'(i) * 64'h0101_0101_0101_0101);
  endfunction

  assign ram_rd_data = mem[ram_addr[8:3]];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (ram_wr_en) begin
      mem[ram_addr[8:3]] <= (mem[ram_addr[8:3]] & ~ram_wmask) | (ram_wr_data & ram_wmask);
    end
  end

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic ref_misalign(input logic [1:0] s, input logic [63:0] a);
    return (int'(a[8:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic ref_fault(input logic [1:0] s, input logic [63:0] a);
`ifdef LSU_RANGE_CHECK_EN
    return (a < 64'h8000_0000) || ((a + 64'(nbytes(s))) > 64'h8800_0000);
`else
    return (s == 2'd0) && (a == 64'h0) && 1'b0;
`endif
  endfunction

  function automatic logic [63:0] ref_load(input logic [1:0] s, input logic uns, input logic [63:0] a);
    logic [63:0] v;
    int n;
    int base;
    v = '0;
    n = nbytes(s);
    base = int'(a[8:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(base + i) % 512];
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] s, input logic [63:0] a, input logic [63:0] wd);
    int base;
    base = int'(a[8:0]);
    for (int i = 0; i < nbytes(s); i++) ref_mem[(base + i) % 512] = wd[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("req_ready_timeout", {63'b0, req_ready}, 64'd1);
  endtask

  task automatic txn(input logic wen, input logic [1:0] size, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                     output logic [63:0] rdata, output logic mis, output logic flt, output int lat,
                     output logic acc_rd, output logic acc_wr, output logic [63:0] acc_addr,
                     output logic [63:0] acc_wmask, output logic [63:0] acc_wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen = wen;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    wait_ready();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_rd = ram_rd_en;
    acc_wr = ram_wr_en;
    acc_addr = ram_addr;
    acc_wmask = ram_wmask;
    acc_wdata = ram_wr_data;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", 64'd0, 64'd1);
    rdata = resp_rdata;
    mis = resp_misalign;
    flt = resp_fault;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {63'b0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, rdata);
      chk("hold_flags", {62'b0, resp_misalign, resp_fault}, {62'b0, mis, flt});
      chk("hold_req_ready", {63'b0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("post_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("post_resp_req_ready", {63'b0, req_ready}, 64'd1);
    if (wen && !ref_misalign(size, addr) && !ref_fault(size, addr)) ref_store(size, addr, wdata);
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [63:0] rd, aa, am, ad, exp_rd, w;
    logic        mi, fl, ar, aw, wen, uns, emis;
    logic [1:0]  sz;
    logic [7:0]  lane_byte;
    int          lat;

    vecs[0]  = '{1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_F566, 1'b0, 2};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'h0, 64'h0000_0000_0000_F566, 1'b0, 2};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_F566_7788, 1'b0, 2};
    vecs[3]  = '{1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 64'h0000_0000_1122_3344, 1'b0, 2};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'hFFFF_FFFF_FFFF_FFF5, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_0000_00F5, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 64'h1122_3344_F566_7788, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 64'h0, 1'b1, 1};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'h0, 64'h0, 1'b1, 1};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 64'h8000_0003, 64'hFFFF_0000_FFFF_0000, 64'h0, 1'b1, 1};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 64'h8000_0007, 64'h0, 64'h0000_0000_0000_0011, 1'b0, 2};

    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = w[8*b +: 8];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", {60'b0, resp_valid, resp_misalign, resp_fault, req_ready}, 64'd0);
    chk("reset_rdata", resp_rdata, 64'd0);
    chk("reset_ram_en", {62'b0, ram_rd_en, ram_wr_en}, 64'd0);
    chk("reset_ram_bus", ram_addr | ram_wmask | ram_wr_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    init_req = 1'b0;
    #1;
    chk("post_reset_req_ready", {63'b0, req_ready}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0,
          rd, mi, fl, lat, ar, aw, aa, am, ad);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_misalign", i), {63'b0, mi}, {63'b0, vecs[i].exp_mis});
      chk($sformatf("vec%0d_fault", i), {63'b0, fl}, 64'd0);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_ram_rd", i), {63'b0, ar}, {63'b0, !vecs[i].wen && !vecs[i].exp_mis});
      chk($sformatf("vec%0d_ram_wr", i), {63'b0, aw}, {63'b0, vecs[i].wen && !vecs[i].exp_mis});
    end

    // Byte store into lane 5, then read it back.
    txn(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00AB, 0, rd, mi, fl, lat, ar, aw, aa, am, ad);
    lane_byte = ad[47:40];
    chk("sb_wr_en", {62'b0, aw, ar}, 64'd2);
    chk("sb_addr", aa, 64'h0000_0000_8000_0000);
    chk("sb_wmask", am, 64'h0000_FF00_0000_0000);
    chk("sb_wdata_lane", {56'b0, lane_byte}, 64'h0000_0000_0000_00AB);
    chk("sb_latency", 64'(lat), 64'd2);
    chk("sb_rdata", rd, 64'd0);
    txn(1'b0, 2'd0, 1'b1, 64'h8000_0005, 64'h0, 0, rd, mi, fl, lat, ar, aw, aa, am, ad);
    chk("lbu_after_sb", rd, 64'h0000_0000_0000_00AB);

    // Dword load with the response held off for five cycles.
    txn(1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 5, rd, mi, fl, lat, ar, aw, aa, am, ad);
    chk("hold_ld_rdata", rd, 64'h1122_AB44_F566_7788);
    chk("hold_ld_latency", 64'(lat), 64'd2);

    // Reset while a store sits in ACCESS.
    @(negedge clk);
    req_valid = 1'b1;
    req_wen = 1'b1;
    req_size = 2'd3;
    req_unsigned = 1'b0;
    req_addr = 64'h8000_0010;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    wait_ready();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_access_wr_before", {63'b0, ram_wr_en}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_access_wr_gated", {63'b0, ram_wr_en}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_abort_resp", {60'b0, resp_valid, resp_misalign, resp_fault, req_ready}, 64'd0);
    chk("rst_abort_ram", {62'b0, ram_rd_en, ram_wr_en} | ram_addr | ram_wmask | ram_wr_data | resp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 0, rd, mi, fl, lat, ar, aw, aa, am, ad);
    chk("rst_no_write", rd, 64'h0123_4567_89AB_CDEF);

    // Out-of-window dword load.
    exp_rd = ref_load(2'd3, 1'b0, 64'h9000_0000);
    txn(1'b0, 2'd3, 1'b0, 64'h9000_0000, 64'h0, 0, rd, mi, fl, lat, ar, aw, aa, am, ad);
`ifdef LSU_RANGE_CHECK_EN
    chk("range_fault", {63'b0, fl}, 64'd1);
    chk("range_rdata", rd, 64'd0);
    chk("range_no_ram", {63'b0, ar}, 64'd0);
    chk("range_latency", 64'(lat), 64'd1);
    txn(1'b0, 2'd2, 1'b0, 64'h9000_0002, 64'h0, 0, rd, mi, fl, lat, ar, aw, aa, am, ad);
    chk("range_both_flags", {62'b0, mi, fl}, 64'd3);
`else
    chk("range_fault", {63'b0, fl}, 64'd0);
    chk("range_rdata", rd, exp_rd);
    chk("range_ram_rd", {63'b0, ar}, 64'd1);
    chk("range_latency", 64'(lat), 64'd2);
`endif

    for (int i = 0; i < 150; i++) begin
      wen = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      aa = 64'h8000_0000 + 64'($urandom_range(0, 511));
      w = {$urandom, $urandom};
      emis = ref_misalign(sz, aa);
      exp_rd = (!wen && !emis) ? ref_load(sz, uns, aa) : 64'd0;
      txn(wen, sz, uns, aa, w, 0, rd, mi, fl, lat, ar, aw, am, am, ad);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_flags", i), {62'b0, mi, fl}, {62'b0, emis, 1'b0});
      chk($sformatf("rnd%0d_latency", i), 64'(lat), emis ? 64'd1 : 64'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
